// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decryption controller: FSM state encoding,
// msgControl encodings and the round count.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_EXP,
        ST_LOAD,
        ST_ARK0,
        ST_ISR,
        ST_ISB_WAIT,
        ST_ISB,
        ST_ARK,
        ST_IMC,
        ST_IMC_LOAD,
        ST_DONE
    } state_e;

    localparam logic [2:0] MSG_ARK  = 3'b000;
    localparam logic [2:0] MSG_ISR  = 3'b001;
    localparam logic [2:0] MSG_IMC  = 3'b010;
    localparam logic [2:0] MSG_ISB  = 3'b011;
    localparam logic [2:0] MSG_LOAD = 3'b100;
    localparam logic [2:0] MSG_HOLD = 3'b111;

endpackage

// File: rtl/aes_decrypt_ctrl.sv
// Moore controller sequencing the AES-128 decryption datapath.
// Optional cycleCount output is built when AES_CTRL_CYCLE_CNT_EN is defined.
module aes_decrypt_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_WAIT = 12
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    output logic       done,
    output logic [2:0] msgControl,
    output logic [1:0] invMixColControl,
    output logic       expandKey,
    output logic [3:0] correctKey
`ifdef AES_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0] cycleCount
`endif
);

    localparam int KW_W = (KEY_WAIT < 1) ? 1 : $clog2(KEY_WAIT + 1);
    localparam logic [KW_W-1:0] KW_LAST = KW_W'(KEY_WAIT - 1);

    state_e          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [1:0]      col_q,   col_d;
    logic [KW_W-1:0] kw_q,    kw_d;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        kw_d    = kw_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KEY_EXP;
                    kw_d    = '0;
                end
            end
            ST_KEY_EXP: begin
                if (kw_q == KW_LAST) state_d = ST_LOAD;
                else                 kw_d    = kw_q + KW_W'(1);
            end
            ST_LOAD:     state_d = ST_ARK0;
            ST_ARK0: begin
                round_d = 4'(NUM_ROUNDS - 1);
                state_d = ST_ISR;
            end
            ST_ISR:      state_d = ST_ISB_WAIT;
            ST_ISB_WAIT: state_d = ST_ISB;
            ST_ISB:      state_d = ST_ARK;
            ST_ARK: begin
                if (round_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    col_d   = 2'd0;
                    state_d = ST_IMC;
                end
            end
            ST_IMC: begin
                // Column counter parks at 3 so IMC_LOAD keeps presenting the last column.
                if (col_q == 2'd3) state_d = ST_IMC_LOAD;
                else               col_d   = col_q + 2'd1;
            end
            ST_IMC_LOAD: begin
                round_d = round_q - 4'd1;
                state_d = ST_ISR;
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            col_q   <= '0;
            kw_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            col_q   <= col_d;
            kw_q    <= kw_d;
        end
    end

    // Outputs decode registered state only; start never reaches them combinationally.
    always_comb begin
        done             = 1'b0;
        msgControl       = MSG_HOLD;
        invMixColControl = 2'd0;
        expandKey        = 1'b0;
        correctKey       = 4'd0;
        case (state_q)
            ST_KEY_EXP:  expandKey  = 1'b1;
            ST_LOAD:     msgControl = MSG_LOAD;
            ST_ARK0: begin
                msgControl = MSG_ARK;
                correctKey = 4'(NUM_ROUNDS);
            end
            ST_ISR:      msgControl = MSG_ISR;
            ST_ISB:      msgControl = MSG_ISB;
            ST_ARK: begin
                msgControl = MSG_ARK;
                correctKey = round_q;
            end
            ST_IMC:      invMixColControl = col_q;
            ST_IMC_LOAD: begin
                msgControl       = MSG_IMC;
                invMixColControl = col_q;
            end
            ST_DONE:     done = 1'b1;
            default: ;
        endcase
    end

`ifdef AES_CTRL_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == ST_IDLE) begin
            if (start) cyc_d = 16'd0;
        end else if (state_q != ST_DONE && cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) cyc_q <= 16'd0;
        else       cyc_q <= cyc_d;
    end

    assign cycleCount = cyc_q;
`else
    // Cycle counter not built in this configuration.
`endif

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl: cycle-by-cycle output trace, latency,
// key-expansion length, start handshake and mid-round reset.
module tb_aes_decrypt_ctrl;

    localparam int KW = 12;
    localparam int LATENCY = KW + 87;

    logic       clk;
    logic       Reset;
    logic       start;
    logic       done;
    logic [2:0] msgControl;
    logic [1:0] invMixColControl;
    logic       expandKey;
    logic [3:0] correctKey;
`ifdef AES_CTRL_CYCLE_CNT_EN
    logic [15:0] cycleCount;
`endif

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];

    aes_decrypt_ctrl #(.KEY_WAIT(KW)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .start            (start),
        .done             (done),
        .msgControl       (msgControl),
        .invMixColControl (invMixColControl),
        .expandKey        (expandKey),
        .correctKey       (correctKey)
`ifdef AES_CTRL_CYCLE_CNT_EN
        ,
        .cycleCount       (cycleCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] w(input logic d, input logic [2:0] m,
                                      input logic [1:0] c, input logic e,
                                      input logic [3:0] k);
        return {d, m, c, e, k};
    endfunction

    function automatic logic [10:0] obs();
        return {done, msgControl, invMixColControl, expandKey, correctKey};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected per-cycle outputs from the first cycle in KEY_EXP through the first DONE cycle.
    task automatic build_expected();
        for (int i = 0; i < KW; i++) exp_q.push_back(w(0, 3'b111, 2'd0, 1, 4'd0));
        exp_q.push_back(w(0, 3'b100, 2'd0, 0, 4'd0));
        exp_q.push_back(w(0, 3'b000, 2'd0, 0, 4'd10));
        for (int r = 9; r >= 1; r--) begin
            exp_q.push_back(w(0, 3'b001, 2'd0, 0, 4'd0));
            exp_q.push_back(w(0, 3'b111, 2'd0, 0, 4'd0));
            exp_q.push_back(w(0, 3'b011, 2'd0, 0, 4'd0));
            exp_q.push_back(w(0, 3'b000, 2'd0, 0, 4'(r)));
            for (int c = 0; c < 4; c++) exp_q.push_back(w(0, 3'b111, 2'(c), 0, 4'd0));
            exp_q.push_back(w(0, 3'b010, 2'd3, 0, 4'd0));
        end
        exp_q.push_back(w(0, 3'b001, 2'd0, 0, 4'd0));
        exp_q.push_back(w(0, 3'b111, 2'd0, 0, 4'd0));
        exp_q.push_back(w(0, 3'b011, 2'd0, 0, 4'd0));
        exp_q.push_back(w(0, 3'b000, 2'd0, 0, 4'd0));
        exp_q.push_back(w(1, 3'b111, 2'd0, 0, 4'd0));
    endtask

    // Raise start, then compare every cycle against the expected trace.
    // drop_at: trace index after which start is lowered (-1 keeps it high).
    // abort_at: trace index after which the task returns early (-1 runs to DONE).
    task automatic run_op(input string name, input int drop_at, input int abort_at);
        int first_done;
        int ek_cycles;
        first_done = -1;
        ek_cycles  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(posedge clk);
            #1;
            check($sformatf("%s_trace[%0d]", name, i), 32'(obs()), 32'(exp_q[i]));
            if (done && first_done < 0) first_done = i;
            if (expandKey) ek_cycles++;
            if (i == abort_at) return;
            if (i == drop_at) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        check({name, "_latency"}, 32'(first_done), 32'(LATENCY));
        check({name, "_expand_cycles"}, 32'(ek_cycles), 32'(KW));
`ifdef AES_CTRL_CYCLE_CNT_EN
        check({name, "_cycle_count"}, 32'(cycleCount), 32'(LATENCY));
`endif
    endtask

    initial begin
        logic [10:0] idle_w;
        logic [10:0] done_w;
        idle_w = w(0, 3'b111, 2'd0, 0, 4'd0);
        done_w = w(1, 3'b111, 2'd0, 0, 4'd0);
        build_expected();

        Reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", 32'(obs()), 32'(idle_w));
`ifdef AES_CTRL_CYCLE_CNT_EN
        check("reset_cycle_count", 32'(cycleCount), 32'd0);
`endif
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_start", 32'(obs()), 32'(idle_w));

        // Single-cycle start pulse.
        run_op("pulse", 0, -1);
        @(posedge clk);
        #1;
        check("pulse_back_to_idle", 32'(obs()), 32'(idle_w));

        // start held through DONE: no restart, done stays high.
        run_op("held", -1, -1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("held_done[%0d]", i), 32'(obs()), 32'(done_w));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("held_release_idle", 32'(obs()), 32'(idle_w));
        @(posedge clk);
        #1;
        check("held_stay_idle", 32'(obs()), 32'(idle_w));

        // start dropped mid-operation: run completes and returns to IDLE.
        run_op("drop", 40, -1);
        @(posedge clk);
        #1;
        check("drop_back_to_idle", 32'(obs()), 32'(idle_w));

        // Reset during the first IMC cycle of round r=5 (trace index KW+42).
        run_op("mid", -1, KW + 42);
        @(negedge clk);
        Reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_idle", 32'(obs()), 32'(idle_w));
`ifdef AES_CTRL_CYCLE_CNT_EN
        check("mid_reset_cycle_count", 32'(cycleCount), 32'd0);
`endif
        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_after_reset_idle", 32'(obs()), 32'(idle_w));

        // A fresh run after the reset must sequence normally.
        run_op("post_reset", 0, -1);
        @(posedge clk);
        #1;
        check("post_reset_idle", 32'(obs()), 32'(idle_w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_ctrl.md
# aes_decrypt_ctrl

Moore controller that sequences the AES-128 decryption datapath through key expansion, initial AddRoundKey, nine full inverse rounds and the final inverse round. It drives the datapath's message-select, InvMixColumns column-select, key-latch and round-key-index controls, and runs a start/done handshake with the top-level (Avalon/NIOS glue). One instance sits beside one datapath instance.

## Interface

Parameters:
- KEY_WAIT, 12, cycles expandKey is held high in the key-expansion state before the schedule is considered valid (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  level request to decrypt the currently presented message/key
- done  out  1  high while a result is held in the datapath message register
- msgControl  out  3  000 AddRoundKey, 001 InvShiftRows, 010 load InvMixColumns result, 011 load InvSubBytes result, 100 load initial message, 111 hold
- invMixColControl  out  2  InvMixColumns column index (0 = bits 31:0 … 3 = bits 127:96)
- expandKey  out  1  latch key schedule into the datapath
- correctKey  out  4  round-key index, 10 (first AddRoundKey) down to 0 (last)

## Operation

- States: IDLE, KEY_EXP, LOAD, ARK0, ISR, ISB_WAIT, ISB, ARK, IMC, IMC_LOAD, DONE.
- Internal counters: round r (4 b, 9 down to 0), column c (2 b), key-wait counter (≥ clog2(KEY_WAIT+1) b).
- IDLE: all outputs at default (msgControl=111, invMixColControl=00, expandKey=0, correctKey=0, done=0). start=1 → KEY_EXP.
- KEY_EXP: expandKey=1 for exactly KEY_WAIT cycles → LOAD.
- LOAD: msgControl=100 → ARK0.
- ARK0: msgControl=000, correctKey=10; r←9 → ISR.
- ISR: msgControl=001 → ISB_WAIT (InvSubBytes ROM has 1-cycle latency).
- ISB_WAIT: msgControl=111 → ISB.
- ISB: msgControl=011 → ARK.
- ARK: msgControl=000, correctKey=r. If r=0 → DONE; else c←0 → IMC.
- IMC: msgControl=111, invMixColControl=c, c increments; after c=3 → IMC_LOAD.
- IMC_LOAD: msgControl=010, invMixColControl held at 3; r decrements → ISR.
- DONE: done=1, msgControl=111; stays until start=0, then → IDLE.
- start is ignored outside IDLE and DONE; deassertion mid-operation does not abort.
- start held high through DONE keeps done=1 (no auto-restart).

## Timing

- All outputs are combinational decode of registered state/counters only; no input→output paths.
- Reset (any state, any cycle) → IDLE on the next edge, counters cleared, outputs at IDLE defaults in the following cycle.
- Latency: done first high KEY_WAIT+87 cycles after the edge that samples start=1 in IDLE (KEY_WAIT + 1 LOAD + 1 ARK0 + 9×9 rounds + 4 final).
- Full round = 9 cycles (ISR, ISB_WAIT, ISB, ARK, 4×IMC, IMC_LOAD); final round = 4 cycles (no IMC).
- correctKey sequence across ARK cycles: 10, 9, 8, …, 1, 0.
- Back-to-back: minimum 1 IDLE cycle between done falling and next KEY_EXP.

## Configuration

- AES_CTRL_CYCLE_CNT_EN defined: adds output cycleCount[15:0], cleared on Reset and on IDLE→KEY_EXP, incremented every non-IDLE/non-DONE cycle, frozen in DONE (reads KEY_WAIT+87); saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure

- Shared package aes_pkg: state enum, msgControl encodings (MSG_ARK, MSG_ISR, MSG_IMC, MSG_ISB, MSG_LOAD, MSG_HOLD), NUM_ROUNDS=10.
- No sub-module; counters and FSM in one module.

## Test plan

- Reset mid-round (during IMC, r=5) → IDLE next cycle, msgControl=111, done=0, expandKey=0.
- start pulse, KEY_WAIT=12 → expandKey high exactly 12 cycles; done rises exactly 99 cycles after start sampled.
- Trace ARK cycles → correctKey 10,9,…,0 each with msgControl=000; IMC columns 0,1,2,3 precede each 010, none after final ARK.
- Integrated with datapath: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → msg 00112233445566778899aabbccddeeff when done=1.
- start held high through DONE → done stays 1, no restart; start low → IDLE, new start → second correct decryption.
- start dropped mid-operation → operation completes, done asserts, returns to IDLE next cycle since start=0.
